// File: rtl/heap_pkg.sv
// heap_pkg: state encoding and key ordering shared by heap_topk and heap_cmp_sel.
//   KEY_MAX_W : widest key the compare function accepts; callers zero-extend narrower keys
//   state_t   : heap_topk controller states
//   key_better: a outranks b (sits nearer the root); equal keys never outrank
package heap_pkg;
  localparam int KEY_MAX_W = 64;
  typedef enum logic [2:0] {IDLE, SIFT_UP, SIFT_DOWN, FLUSH_POP, FLUSH_SIFT} state_t;
  function automatic logic key_better(input logic [KEY_MAX_W-1:0] a, input logic [KEY_MAX_W-1:0] b, input logic max_mode);
    return max_mode ? (a > b) : (a < b);
  endfunction
endpackage

// File: rtl/heap_cmp_sel.sv
// heap_cmp_sel: picks the better of two candidate keys and flags whether it outranks a top key.
//   top_key        : key currently above the candidates
//   b_key/b_ok     : first candidate (wins ties) and its presence
//   c_key/c_ok     : second candidate and its presence
//   sel_c          : second candidate chosen
//   swap           : chosen candidate outranks top_key
module heap_cmp_sel import heap_pkg::*; #(
  parameter int KEY_WIDTH = 16,
  parameter int MAX_MODE  = 0
) (
  input  logic [KEY_WIDTH-1:0] top_key,
  input  logic [KEY_WIDTH-1:0] b_key,
  input  logic                 b_ok,
  input  logic [KEY_WIDTH-1:0] c_key,
  input  logic                 c_ok,
  output logic                 sel_c,
  output logic                 swap
);
  always_comb begin
    sel_c = c_ok && (!b_ok || key_better(KEY_MAX_W'(c_key), KEY_MAX_W'(b_key), MAX_MODE != 0));
    swap  = sel_c ? key_better(KEY_MAX_W'(c_key), KEY_MAX_W'(top_key), MAX_MODE != 0)
                  : b_ok && key_better(KEY_MAX_W'(b_key), KEY_MAX_W'(top_key), MAX_MODE != 0);
  end
endmodule

// File: rtl/heap_topk.sv
// heap_topk: streaming top-K filter built on a binary heap of 2^NLEVELS-1 entries.
//   clk, rstn (async, active-low)
//   in_data/in_valid/in_ready    : element stream in
//   out_data/out_valid/out_ready : bypassed, evicted or drained elements out
//   init  : synchronous clear, overrides everything
//   flush : drain request pulse; flush_done pulses when the drain completes
//   count : heap occupancy
//   evict_cnt : saturating eviction counter, present only with HEAP_TOPK_STATS_EN defined
module heap_topk import heap_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH  = 16,
  parameter int NLEVELS    = 3,
  parameter int MAX_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  init,
  input  logic                  flush,
  output logic                  flush_done,
  output logic [NLEVELS-1:0]    count
`ifdef HEAP_TOPK_STATS_EN
  ,
  output logic [15:0]           evict_cnt
`endif
);
  localparam int HEAP_SIZE = 2**NLEVELS - 1;
  localparam logic [NLEVELS-1:0] FULL = '1;
  state_t state_q, state_d, sift_ret;
  logic [NLEVELS-1:0] count_q, count_d, idx_q, idx_d, par, lc_i, rc_i, ch;
  logic [NLEVELS:0] lc, rc;
  logic pend_q, pend_d, out_valid_q, out_valid_d, flush_done_q, flush_done_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0] heap_q [HEAP_SIZE];
  logic [DATA_WIDTH-1:0] heap_d [HEAP_SIZE];
  logic lc_ok, rc_ok, ch_kids, up_sel, up_swap, dn_sel, dn_swap, root_wins;
  assign in_ready   = state_q == IDLE && !pend_q && (!out_valid_q || out_ready);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign flush_done = flush_done_q;
  assign count      = count_q;
  assign root_wins  = key_better(KEY_MAX_W'(heap_q[0][KEY_WIDTH-1:0]), KEY_MAX_W'(in_data[KEY_WIDTH-1:0]), MAX_MODE != 0);
  // Child indices are one bit wider so 2i+1/2i+2 never wrap; out-of-range children read slot 0 and are masked.
  always_comb begin
    par     = idx_q == '0 ? '0 : (idx_q - 1'b1) >> 1;
    lc      = {idx_q, 1'b1};
    rc      = lc + 1'b1;
    lc_ok   = lc < {1'b0, count_q};
    rc_ok   = rc < {1'b0, count_q};
    lc_i    = lc_ok ? lc[NLEVELS-1:0] : '0;
    rc_i    = rc_ok ? rc[NLEVELS-1:0] : '0;
    ch      = dn_sel ? rc_i : lc_i;
    ch_kids = {ch, 1'b1} < {1'b0, count_q};
    sift_ret = state_q == FLUSH_SIFT ? FLUSH_POP : IDLE;
  end
  // Sift-up feeds the node as the sole candidate against its parent; a root node has no candidate.
  heap_cmp_sel #(.KEY_WIDTH(KEY_WIDTH), .MAX_MODE(MAX_MODE)) u_up (
    .top_key(heap_q[par][KEY_WIDTH-1:0]),
    .b_key  ('0),
    .b_ok   (1'b0),
    .c_key  (heap_q[idx_q][KEY_WIDTH-1:0]),
    .c_ok   (idx_q != '0),
    .sel_c  (up_sel),
    .swap   (up_swap)
  );
  heap_cmp_sel #(.KEY_WIDTH(KEY_WIDTH), .MAX_MODE(MAX_MODE)) u_dn (
    .top_key(heap_q[idx_q][KEY_WIDTH-1:0]),
    .b_key  (heap_q[lc_i][KEY_WIDTH-1:0]),
    .b_ok   (lc_ok),
    .c_key  (heap_q[rc_i][KEY_WIDTH-1:0]),
    .c_ok   (rc_ok),
    .sel_c  (dn_sel),
    .swap   (dn_swap)
  );
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    idx_d        = idx_q;
    pend_d       = pend_q | flush;
    out_valid_d  = out_valid_q && !out_ready;
    out_data_d   = out_data_q;
    flush_done_d = 1'b0;
    heap_d       = heap_q;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = FLUSH_POP;
          pend_d  = flush;
        end else if (in_valid && in_ready) begin
          if (count_q != FULL) begin
            heap_d[count_q] = in_data;
            count_d         = count_q + 1'b1;
            idx_d           = count_q;
            state_d         = SIFT_UP;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = root_wins ? heap_q[0] : in_data;
            if (root_wins) begin
              heap_d[0] = in_data;
              idx_d     = '0;
              state_d   = SIFT_DOWN;
            end
          end
        end
      end
      SIFT_UP: begin
        if (up_sel && up_swap) begin
          heap_d[par]   = heap_q[idx_q];
          heap_d[idx_q] = heap_q[par];
          idx_d         = par;
          state_d       = par == '0 ? IDLE : SIFT_UP;
        end else begin
          state_d = IDLE;
        end
      end
      SIFT_DOWN, FLUSH_SIFT: begin
        // Landing on a node without children ends the sift in the same cycle as the last swap.
        if (dn_swap) begin
          heap_d[ch]    = heap_q[idx_q];
          heap_d[idx_q] = heap_q[ch];
          idx_d         = ch;
          state_d       = ch_kids ? state_q : sift_ret;
        end else begin
          state_d = sift_ret;
        end
      end
      FLUSH_POP: begin
        if (count_q == '0) begin
          flush_done_d = 1'b1;
          state_d      = IDLE;
        end else if (!out_valid_q || out_ready) begin
          out_valid_d  = 1'b1;
          out_data_d   = heap_q[0];
          heap_d[0]    = heap_q[count_q - 1'b1];
          count_d      = count_q - 1'b1;
          idx_d        = '0;
          flush_done_d = count_q == NLEVELS'(1);
          state_d      = count_q == NLEVELS'(1) ? IDLE : FLUSH_SIFT;
        end
      end
      default: state_d = IDLE;
    endcase
    if (init) begin
      state_d      = IDLE;
      count_d      = '0;
      idx_d        = '0;
      pend_d       = 1'b0;
      out_valid_d  = 1'b0;
      flush_done_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      count_q      <= '0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      flush_done_q <= flush_done_d;
    end
  end
  always_ff @(posedge clk) heap_q <= heap_d;
`ifdef HEAP_TOPK_STATS_EN
  logic [15:0] evict_cnt_q, evict_cnt_d;
  logic evict;
  assign evict     = in_valid && in_ready && count_q == FULL && root_wins;
  assign evict_cnt = evict_cnt_q;
  always_comb evict_cnt_d = init ? '0 : (evict && evict_cnt_q != 16'hFFFF) ? evict_cnt_q + 1'b1 : evict_cnt_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) evict_cnt_q <= '0;
    else       evict_cnt_q <= evict_cnt_d;
  end
`endif
endmodule
